reg_writeback_queue: RTL and testbench

//   Writer-side front end for the 32x32 register file write port (RDaddr/RDdata/RegWrite).

---
 rtl/reg_writeback_queue_if.sv | 49 ++++
 rtl/reg_writeback_queue.sv | 155 +++++++++++++++
 tb/tb_reg_writeback_queue.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/reg_writeback_queue_if.sv
// Write-back bus between the result producers and the register-file write port.
// The queue sits on the slave side; producers and register-file logic use master.
interface reg_writeback_queue_if #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned DW    = 32,
    parameter int unsigned AW    = 5
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic          pipe_valid;
    logic [AW-1:0] pipe_addr;
    logic [DW-1:0] pipe_data;
    logic          pipe_stall;

    logic          ll_valid;
    logic [AW-1:0] ll_addr;
    logic [DW-1:0] ll_data;
    logic          ll_ready;

    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          reg_write;

    logic [AW-1:0] fwd_addr;
    logic          fwd_hit_c;
    logic [DW-1:0] fwd_data_c;

    logic [CW-1:0] count;

    modport master (
        output pipe_valid, pipe_addr, pipe_data,
        output ll_valid, ll_addr, ll_data,
        output fwd_addr,
        input  pipe_stall, ll_ready,
        input  rd_addr, rd_data, reg_write,
        input  fwd_hit_c, fwd_data_c,
        input  count
    );

    modport slave (
        input  pipe_valid, pipe_addr, pipe_data,
        input  ll_valid, ll_addr, ll_data,
        input  fwd_addr,
        output pipe_stall, ll_ready,
        output rd_addr, rd_data, reg_write,
        output fwd_hit_c, fwd_data_c,
        output count
    );
endinterface

// File: rtl/reg_writeback_queue.sv
// Merges the in-order WB result and a FIFO of long-latency results onto the single
// register-file write port, with a starvation-forced drain and a forwarding lookup.
module reg_writeback_queue #(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned DW         = 32,
    parameter int unsigned AW         = 5,
    parameter int unsigned STARVE_MAX = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    reg_writeback_queue_if.slave bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned SW = $clog2(STARVE_MAX + 1);

    typedef enum logic [0:0] {
        NORMAL = 1'b0,
        DRAIN  = 1'b1
    } state_t;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } entry_t;

    entry_t        mem [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_nxt;
    logic          ready_q, ready_nxt;
    logic [SW-1:0] starve_q, starve_nxt;
    state_t        state_q, state_nxt;
    logic          stall_q, stall_nxt;
    logic          we_q, we_nxt;
    logic [AW-1:0] rd_addr_q, addr_nxt;
    logic [DW-1:0] rd_data_q, data_nxt;
    logic          push, pop, pipe_win, nonempty;
    entry_t        head;
    logic          fwd_hit;
    logic [DW-1:0] fwd_data;

    assign head     = mem[rd_ptr_q];
    assign nonempty = (count_q != '0);

    // Arbitration, starvation tracking and next-state for the write port.
    always_comb begin
        state_nxt  = state_q;
        starve_nxt = starve_q;
        stall_nxt  = 1'b0;
        pop        = 1'b0;
        we_nxt     = 1'b0;
        addr_nxt   = rd_addr_q;
        data_nxt   = rd_data_q;
        pipe_win   = bus.pipe_valid && (bus.pipe_addr != '0);
        // Address-0 results complete the handshake but are never stored.
        push       = bus.ll_valid && ready_q && (bus.ll_addr != '0);

        unique case (state_q)
            NORMAL: begin
                if (pipe_win) begin
                    we_nxt     = 1'b1;
                    addr_nxt   = bus.pipe_addr;
                    data_nxt   = bus.pipe_data;
                    starve_nxt = nonempty ? (starve_q + SW'(1)) : '0;
                end else if (nonempty) begin
                    pop        = 1'b1;
                    we_nxt     = 1'b1;
                    addr_nxt   = head.addr;
                    data_nxt   = head.data;
                    starve_nxt = '0;
                end else begin
                    starve_nxt = '0;
                end
                if (starve_nxt == SW'(STARVE_MAX)) begin
                    state_nxt = DRAIN;
                    stall_nxt = 1'b1;
                end
            end
            DRAIN: begin
                // Pipeline is held this cycle; the head wins unconditionally.
                if (nonempty) begin
                    pop      = 1'b1;
                    we_nxt   = 1'b1;
                    addr_nxt = head.addr;
                    data_nxt = head.data;
                end
                starve_nxt = '0;
                state_nxt  = NORMAL;
            end
            default: state_nxt = NORMAL;
        endcase

        count_nxt = count_q + CW'(push) - CW'(pop);
        ready_nxt = (count_nxt != CW'(DEPTH));
    end

    // State and output registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= NORMAL;
            starve_q  <= '0;
            stall_q   <= 1'b0;
            we_q      <= 1'b0;
            rd_addr_q <= '0;
            rd_data_q <= '0;
            count_q   <= '0;
            ready_q   <= 1'b1;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
        end else begin
            state_q   <= state_nxt;
            starve_q  <= starve_nxt;
            stall_q   <= stall_nxt;
            we_q      <= we_nxt;
            rd_addr_q <= addr_nxt;
            rd_data_q <= data_nxt;
            count_q   <= count_nxt;
            ready_q   <= ready_nxt;
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
        end
    end

    // Storage needs no reset: occupancy gates every read.
    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr_q] <= '{addr: bus.ll_addr, data: bus.ll_data};
    end

    // Forwarding: output register first, then FIFO oldest-to-youngest so the youngest wins.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        if (bus.fwd_addr != '0) begin
            if (we_q && (rd_addr_q == bus.fwd_addr)) begin
                fwd_hit  = 1'b1;
                fwd_data = rd_data_q;
            end
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if ((CW'(i) < count_q) && (mem[rd_ptr_q + PW'(i)].addr == bus.fwd_addr)) begin
                    fwd_hit  = 1'b1;
                    fwd_data = mem[rd_ptr_q + PW'(i)].data;
                end
            end
        end
    end

    assign bus.pipe_stall = stall_q;
    assign bus.ll_ready   = ready_q;
    assign bus.rd_addr    = rd_addr_q;
    assign bus.rd_data    = rd_data_q;
    assign bus.reg_write  = we_q;
    assign bus.count      = count_q;
    assign bus.fwd_hit_c  = fwd_hit;
    assign bus.fwd_data_c = fwd_data;
endmodule

// File: tb/tb_reg_writeback_queue.sv
// Bench for reg_writeback_queue: directed vector table, hand sequences for the forced
// drain and mid-operation reset, then random traffic against a queue-based model.
module tb_reg_writeback_queue;
    localparam int DEPTH      = 4;
    localparam int STARVE_MAX = 8;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    reg_writeback_queue_if #(.DEPTH(DEPTH), .DW(32), .AW(5)) bus ();

    reg_writeback_queue #(
        .DEPTH(DEPTH), .DW(32), .AW(5), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk_i  (clk),
        .rst_n_i(rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        pv;
        logic [4:0]  pa;
        logic [31:0] pd;
        logic        lv;
        logic [4:0]  la;
        logic [31:0] ld;
        logic [4:0]  fa;
        logic        we;
        logic [4:0]  ea;
        logic [31:0] ed;
        logic [2:0]  ec;
        logic        er;
        logic        es;
        logic        eh;
        logic [31:0] efd;
    } vec_t;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    vec_t vecs [17];

    // Reference model state: pending long-latency results and the write-port register.
    ent_t        mq[$];
    int          m_starve;
    bit          m_drain;
    logic        m_we;
    logic [4:0]  m_addr;
    logic [31:0] m_data;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic check_outs(string tag, logic we, logic [4:0] ea, logic [31:0] ed,
                              logic [2:0] ec, logic er, logic es, logic eh, logic [31:0] efd);
        chk({tag, ".reg_write"},  32'(bus.reg_write),  32'(we));
        chk({tag, ".rd_addr"},    32'(bus.rd_addr),    32'(ea));
        chk({tag, ".rd_data"},    bus.rd_data,         ed);
        chk({tag, ".count"},      32'(bus.count),      32'(ec));
        chk({tag, ".ll_ready"},   32'(bus.ll_ready),   32'(er));
        chk({tag, ".pipe_stall"}, 32'(bus.pipe_stall), 32'(es));
        chk({tag, ".fwd_hit"},    32'(bus.fwd_hit_c),  32'(eh));
        chk({tag, ".fwd_data"},   bus.fwd_data_c,      efd);
    endtask

    task automatic drive(logic pv, logic [4:0] pa, logic [31:0] pd,
                         logic lv, logic [4:0] la, logic [31:0] ld, logic [4:0] fa);
        bus.pipe_valid = pv;
        bus.pipe_addr  = pa;
        bus.pipe_data  = pd;
        bus.ll_valid   = lv;
        bus.ll_addr    = la;
        bus.ll_data    = ld;
        bus.fwd_addr   = fa;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // One clock of the model: drain cycle or priority arbitration, then the accepted push.
    task automatic model_step(logic pv, logic [4:0] pa, logic [31:0] pd,
                              logic lv, logic [4:0] la, logic [31:0] ld);
        bit   take;
        ent_t h;
        take = lv && (mq.size() < DEPTH) && (la != 5'd0);
        m_we = 1'b0;
        if (m_drain) begin
            if (mq.size() > 0) begin
                h = mq.pop_front();
                m_we = 1'b1; m_addr = h.a; m_data = h.d;
            end
            m_starve = 0;
            m_drain  = 1'b0;
        end else if (pv && (pa != 5'd0)) begin
            m_we = 1'b1; m_addr = pa; m_data = pd;
            m_starve = (mq.size() > 0) ? m_starve + 1 : 0;
            if (m_starve == STARVE_MAX) m_drain = 1'b1;
        end else if (mq.size() > 0) begin
            h = mq.pop_front();
            m_we = 1'b1; m_addr = h.a; m_data = h.d;
            m_starve = 0;
        end else begin
            m_starve = 0;
        end
        if (take) mq.push_back('{a: la, d: ld});
    endtask

    task automatic model_fwd(logic [4:0] fa, output logic hit, output logic [31:0] fd);
        hit = 1'b0;
        fd  = 32'd0;
        if (fa != 5'd0) begin
            if (m_we && (m_addr == fa)) begin hit = 1'b1; fd = m_data; end
            foreach (mq[k]) if (mq[k].a == fa) begin hit = 1'b1; fd = mq[k].d; end
        end
    endtask

    initial begin
        logic        pv, lv, eh;
        logic [4:0]  pa, la, fa;
        logic [31:0] pd, ld, efd;
        int          pct;

        checks = 0;
        errors = 0;
        //         pv    pa     pd            lv    la      ld          fa      we    ea      ed            ec    er    es    eh    efd
        vecs[0]  = '{1'b1, 5'd3,  32'hDEADBEEF, 1'b0, 5'd0,  32'h0,     5'd3,  1'b1, 5'd3,  32'hDEADBEEF, 3'd0, 1'b1, 1'b0, 1'b1, 32'hDEADBEEF};
        vecs[1]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,     5'd3,  1'b0, 5'd3,  32'hDEADBEEF, 3'd0, 1'b1, 1'b0, 1'b0, 32'h0};
        vecs[2]  = '{1'b1, 5'd1,  32'h101,      1'b1, 5'd8,  32'h80,    5'd8,  1'b1, 5'd1,  32'h101,      3'd1, 1'b1, 1'b0, 1'b1, 32'h80};
        vecs[3]  = '{1'b1, 5'd2,  32'h102,      1'b1, 5'd9,  32'h90,    5'd1,  1'b1, 5'd2,  32'h102,      3'd2, 1'b1, 1'b0, 1'b0, 32'h0};
        vecs[4]  = '{1'b1, 5'd4,  32'h104,      1'b1, 5'd10, 32'hA0,    5'd2,  1'b1, 5'd4,  32'h104,      3'd3, 1'b1, 1'b0, 1'b0, 32'h0};
        vecs[5]  = '{1'b1, 5'd6,  32'h106,      1'b1, 5'd11, 32'hB0,    5'd11, 1'b1, 5'd6,  32'h106,      3'd4, 1'b0, 1'b0, 1'b1, 32'hB0};
        vecs[6]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd12, 32'hC0,    5'd12, 1'b1, 5'd8,  32'h80,       3'd3, 1'b1, 1'b0, 1'b0, 32'h0};
        vecs[7]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,     5'd9,  1'b1, 5'd9,  32'h90,       3'd2, 1'b1, 1'b0, 1'b1, 32'h90};
        vecs[8]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,     5'd0,  1'b1, 5'd10, 32'hA0,       3'd1, 1'b1, 1'b0, 1'b0, 32'h0};
        vecs[9]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,     5'd10, 1'b1, 5'd11, 32'hB0,       3'd0, 1'b1, 1'b0, 1'b0, 32'h0};
        vecs[10] = '{1'b1, 5'd0,  32'h55,       1'b1, 5'd0,  32'h66,    5'd0,  1'b0, 5'd11, 32'hB0,       3'd0, 1'b1, 1'b0, 1'b0, 32'h0};
        vecs[11] = '{1'b1, 5'd7,  32'h107,      1'b1, 5'd5,  32'h11,    5'd5,  1'b1, 5'd7,  32'h107,      3'd1, 1'b1, 1'b0, 1'b1, 32'h11};
        vecs[12] = '{1'b1, 5'd13, 32'h10D,      1'b1, 5'd5,  32'h22,    5'd5,  1'b1, 5'd13, 32'h10D,      3'd2, 1'b1, 1'b0, 1'b1, 32'h22};
        vecs[13] = '{1'b1, 5'd14, 32'h10E,      1'b0, 5'd0,  32'h0,     5'd0,  1'b1, 5'd14, 32'h10E,      3'd2, 1'b1, 1'b0, 1'b0, 32'h0};
        vecs[14] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,     5'd5,  1'b1, 5'd5,  32'h11,       3'd1, 1'b1, 1'b0, 1'b1, 32'h22};
        vecs[15] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,     5'd5,  1'b1, 5'd5,  32'h22,       3'd0, 1'b1, 1'b0, 1'b1, 32'h22};
        vecs[16] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,     5'd5,  1'b0, 5'd5,  32'h22,       3'd0, 1'b1, 1'b0, 1'b0, 32'h0};

        rst_n = 1'b0;
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0);
        cycle();
        check_outs("reset", 1'b0, 5'd0, 32'd0, 3'd0, 1'b1, 1'b0, 1'b0, 32'd0);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].pv, vecs[i].pa, vecs[i].pd, vecs[i].lv, vecs[i].la, vecs[i].ld, vecs[i].fa);
            cycle();
            check_outs($sformatf("vec%0d", i), vecs[i].we, vecs[i].ea, vecs[i].ed,
                       vecs[i].ec, vecs[i].er, vecs[i].es, vecs[i].eh, vecs[i].efd);
        end

        // Head (addr 9) loses eight times, then one stall cycle drains it.
        drive(1'b1, 5'd1, 32'h301, 1'b1, 5'd9, 32'h99, 5'd9);
        cycle();
        chk("starve.count", 32'(bus.count), 32'd1);
        chk("starve.fwd", bus.fwd_data_c, 32'h99);
        for (int k = 1; k <= STARVE_MAX; k++) begin
            drive(1'b1, 5'(k + 1), 32'h300 + 32'(k), 1'b0, 5'd0, 32'd0, 5'd0);
            cycle();
            chk($sformatf("starve.stall%0d", k), 32'(bus.pipe_stall), (k == STARVE_MAX) ? 32'd1 : 32'd0);
            chk($sformatf("starve.addr%0d", k), 32'(bus.rd_addr), 32'(k + 1));
        end
        drive(1'b1, 5'd20, 32'h314, 1'b0, 5'd0, 32'd0, 5'd0);
        cycle();
        check_outs("drain", 1'b1, 5'd9, 32'h99, 3'd0, 1'b1, 1'b0, 1'b0, 32'd0);
        cycle();
        check_outs("represent", 1'b1, 5'd20, 32'h314, 3'd0, 1'b1, 1'b0, 1'b0, 32'd0);

        // Asynchronous reset with three results queued.
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 5'(21 + k), 32'h400 + 32'(k), 1'b1, 5'(16 + k), 32'h500 + 32'(k), 5'd0);
            cycle();
        end
        chk("prereset.count", 32'(bus.count), 32'd3);
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd16);
        rst_n = 1'b0;
        #2;
        chk("midreset.count", 32'(bus.count), 32'd0);
        chk("midreset.reg_write", 32'(bus.reg_write), 32'd0);
        chk("midreset.stall", 32'(bus.pipe_stall), 32'd0);
        chk("midreset.fwd_hit", 32'(bus.fwd_hit_c), 32'd0);
        cycle();
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cycle();
            check_outs($sformatf("postreset%0d", k), 1'b0, 5'd0, 32'd0, 3'd0, 1'b1, 1'b0, 1'b0, 32'd0);
        end

        // Random traffic, alternating light and heavy pipeline load to exercise drains.
        mq.delete();
        m_starve = 0; m_drain = 1'b0; m_we = 1'b0; m_addr = 5'd0; m_data = 32'd0;
        for (int i = 0; i < 600; i++) begin
            pct = ((i / 100) % 2 == 1) ? 90 : 35;
            pv  = ($urandom_range(0, 99) < pct);
            pa  = 5'($urandom_range(0, 31));
            pd  = $urandom;
            lv  = 1'($urandom_range(0, 1));
            la  = 5'($urandom_range(0, 31));
            ld  = $urandom;
            fa  = 5'($urandom_range(0, 31));
            drive(pv, pa, pd, lv, la, ld, fa);
            model_step(pv, pa, pd, lv, la, ld);
            cycle();
            model_fwd(fa, eh, efd);
            check_outs($sformatf("rand%0d", i), m_we, m_addr, m_data, 3'(mq.size()),
                       (mq.size() < DEPTH), m_drain, eh, efd);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
